// File: rtl/instr_pkg.sv
// Shared opcode/func map, request kinds, loader states and the instruction-word packer
// used by both the encoder front end and the single-cycle controller.
package instr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd1;
  localparam logic [5:0] OP_SW    = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd3;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_OR  = 6'd3;

  typedef enum logic [2:0] {
    KIND_ADD = 3'd0,
    KIND_SUB = 3'd1,
    KIND_AND = 3'd2,
    KIND_OR  = 3'd3,
    KIND_LW  = 3'd4,
    KIND_SW  = 3'd5,
    KIND_BEQ = 3'd6,
    KIND_ILL = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  // Illegal kinds pack to all-zero, which decodes as ADD r0,r0,r0 (a no-op).
  function automatic logic [31:0] encode(input kind_e kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    case (kind)
      KIND_ADD: w = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_ADD};
      KIND_SUB: w = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_SUB};
      KIND_AND: w = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_AND};
      KIND_OR:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FUNC_OR};
      KIND_LW:  w = {OP_LW, rs, rt, imm};
      KIND_SW:  w = {OP_SW, rs, rt, imm};
      KIND_BEQ: w = {OP_BEQ, rs, rt, imm};
      default:  w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of encoded words; read data is the head entry, visible combinationally.
// Caller never pushes when full nor pops when empty; push and pop may share an edge.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     occ_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   occ_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (occ_q == (PW+1)'(DEPTH));
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes symbolic requests into 32-bit words and streams them to consecutive imem addresses.
// Optional macro ENC_ILLEGAL_CHECK_EN drops kind-7 beats and raises a sticky err instead.
module instr_stream_encoder
  import instr_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              seal,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = ((ADDR_W > OCC_W) ? ADDR_W : OCC_W) + 2;

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              fifo_full, fifo_empty, push, pop, accept, wr_fire, start_ok;
  logic [OCC_W-1:0]  fifo_occ;
  logic [31:0]       fifo_dout, enc_word;
  logic [SUM_W-1:0]  inflight;

  // Every word already committed, queued or on the port reserves one address.
  assign inflight = SUM_W'(count_q) + SUM_W'(fifo_occ) + SUM_W'(we_q);
  assign in_ready = (state_q == ST_RUN) & ~fifo_full & (inflight < (SUM_W'(1) << ADDR_W));
  assign accept   = in_valid & in_ready;
  assign enc_word = encode(kind_e'(in_kind), in_rs, in_rt, in_rd, in_imm);
  assign wr_fire  = we_q & imem_ready;
  assign pop      = ~fifo_empty & (~we_q | imem_ready);
  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

`ifdef ENC_ILLEGAL_CHECK_EN
  logic err_q, illegal;
  assign illegal = (in_kind == KIND_ILL);
  assign push    = accept & ~illegal;
  always_ff @(posedge clk) begin
    if (rst)                    err_q <= 1'b0;
    else if (start_ok)          err_q <= 1'b0;
    else if (accept & illegal)  err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign push = accept;
  assign err  = 1'b0;
`endif

  instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (enc_word),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .occ_o   (fifo_occ)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (wr_fire) begin
      addr_d  = addr_q + 1'b1;
      count_d = count_q + 1'b1;
      we_d    = 1'b0;
    end
    if (pop) begin
      we_d    = 1'b1;
      wdata_d = fifo_dout;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = ADDR_W'(BASE_ADDR);
          count_d = '0;
        end
      end
      ST_RUN:   if (seal) state_d = ST_DRAIN;
      // Leave as the last write completes so done shows on the following cycle.
      ST_DRAIN: if (fifo_empty & (~we_q | imem_ready)) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign count      = count_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: a wide instance (ADDR_W=8) and a tiny one (ADDR_W=2)
// share all inputs except start; a queue-level model is checked against both every cycle.
module tb_instr_stream_encoder;

  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, seal = 1'b0;
  logic in_valid = 1'b0, imem_ready = 1'b1;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;

  logic rdy_a, we_a, busy_a, done_a, err_a;
  logic [7:0] addr_a; logic [31:0] wd_a; logic [8:0] cnt_a;
  logic rdy_b, we_b, busy_b, done_b, err_b;
  logic [1:0] addr_b; logic [31:0] wd_b; logic [2:0] cnt_b;

  int total = 0, bad = 0;
  bit live = 1'b0;
  logic [39:0] log_a[$], log_b[$];

  always #5 clk = ~clk;

  instr_stream_encoder #(.DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seal(seal), .in_valid(in_valid), .in_ready(rdy_a),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .imem_we(we_a), .imem_ready(imem_ready), .imem_addr(addr_a), .imem_wdata(wd_a),
    .busy(busy_a), .done(done_a), .count(cnt_a), .err(err_a));

  instr_stream_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seal(seal), .in_valid(in_valid), .in_ready(rdy_b),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .imem_we(we_b), .imem_ready(imem_ready), .imem_addr(addr_b), .imem_wdata(wd_b),
    .busy(busy_b), .done(done_b), .count(cnt_b), .err(err_b));

  // ---------------- model: mode 0 idle, 1 run, 2 drain, 3 done ----------------
  int          m_mode[2], m_occ[2], m_addr[2], m_cnt[2];
  bit          m_we[2], m_err[2];
  logic [31:0] m_wd[2];
  logic [31:0] m_q[2][8];

  function automatic logic [31:0] ref_word(input int kind, input int rs, input int rt,
                                           input int rd, input int imm);
    if (kind < 4)  return 32'((rs << 21) | (rt << 16) | (rd << 11) | kind);
    if (kind == 7) return 32'd0;
    return 32'(((kind - 3) << 26) | (rs << 21) | (rt << 16) | (imm & 32'hFFFF));
  endfunction

  function automatic bit exp_rdy(input int k, input int aw);
    return m_mode[k] == 1 && m_occ[k] < 4 && (m_cnt[k] + m_occ[k] + int'(m_we[k])) < (1 << aw);
  endfunction

  task automatic step(input int k, input int aw, input logic st);
    bit acc, fire, legal;
    if (rst) begin
      m_mode[k] = 0; m_occ[k] = 0; m_addr[k] = 0; m_cnt[k] = 0;
      m_we[k] = 1'b0; m_err[k] = 1'b0; m_wd[k] = '0;
      return;
    end
    acc  = in_valid && exp_rdy(k, aw);
    fire = m_we[k] && imem_ready;
    if (fire) begin m_addr[k]++; m_cnt[k]++; end
    if (m_occ[k] > 0 && (!m_we[k] || fire)) begin
      m_wd[k] = m_q[k][0];
      for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
      m_occ[k]--;
      m_we[k] = 1'b1;
    end else if (fire) begin
      m_we[k] = 1'b0;
    end
    legal = 1'b1;
`ifdef ENC_ILLEGAL_CHECK_EN
    legal = (in_kind != 3'd7);
    if (acc && !legal) m_err[k] = 1'b1;
`endif
    if (acc && legal) begin
      m_q[k][m_occ[k]] = ref_word(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
      m_occ[k]++;
    end
    case (m_mode[k])
      0, 3: if (st) begin m_mode[k] = 1; m_cnt[k] = 0; m_err[k] = 1'b0; m_addr[k] = 0; end
      1:    if (seal) m_mode[k] = 2;
      2:    if (m_occ[k] == 0 && !m_we[k]) m_mode[k] = 3;
      default: m_mode[k] = 0;
    endcase
  endtask

  always @(posedge clk) begin
    step(0, 8, start_a);
    step(1, 2, start_b);
    live = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++; bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic cmp(input int k, input int aw, input logic r, input logic we,
                     input logic [31:0] ad, input logic [31:0] wd, input logic b,
                     input logic d, input logic [31:0] c, input logic e);
    chk($sformatf("m%0d_in_ready", k), 64'(r), 64'(exp_rdy(k, aw)));
    chk($sformatf("m%0d_imem_we", k), 64'(we), 64'(m_we[k]));
    chk($sformatf("m%0d_imem_addr", k), 64'(ad), 64'(m_addr[k] % (1 << aw)));
    chk($sformatf("m%0d_imem_wdata", k), 64'(wd), 64'(m_wd[k]));
    chk($sformatf("m%0d_busy", k), 64'(b), 64'(m_mode[k] == 1 || m_mode[k] == 2));
    chk($sformatf("m%0d_done", k), 64'(d), 64'(m_mode[k] == 3));
    chk($sformatf("m%0d_count", k), 64'(c), 64'(m_cnt[k]));
    chk($sformatf("m%0d_err", k), 64'(e), 64'(m_err[k]));
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp(0, 8, rdy_a, we_a, 32'(addr_a), wd_a, busy_a, done_a, 32'(cnt_a), err_a);
      cmp(1, 2, rdy_b, we_b, 32'(addr_b), wd_b, busy_b, done_b, 32'(cnt_b), err_b);
      if (!rst && we_a && imem_ready) log_a.push_back({addr_a, wd_a});
      if (!rst && we_b && imem_ready) log_b.push_back({6'd0, addr_b, wd_b});
    end
  end

  task automatic chk_log(input string name, input int k, input int i, input logic [39:0] exp);
    if (k == 0 && i < log_a.size())      chk(name, 64'(log_a[i]), 64'(exp));
    else if (k == 1 && i < log_b.size()) chk(name, 64'(log_b[i]), 64'(exp));
    else begin
      total++; bad++;
      $display("FAIL %s: write %0d missing, expected %0h", name, i, exp);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input bit a, input bit b);
    start_a = a; start_b = b;
    tick();
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic drive(input int kind, input int rs, input int rt, input int rd, input int imm);
    in_valid = 1'b1;
    in_kind = 3'(kind); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_imm = 16'(imm);
  endtask

  task automatic send(input int kind, input int rs, input int rt, input int rd, input int imm,
                      input bit with_seal, input int k);
    bit r;
    drive(kind, rs, rt, rd, imm);
    seal = with_seal;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      r = (k == 0) ? rdy_a : rdy_b;
      tick();
      seal = 1'b0;
      if (r) break;
      if (n == 49) timeout("send");
    end
    in_valid = 1'b0;
  endtask

  task automatic do_seal();
    seal = 1'b1; tick(); seal = 1'b0;
  endtask

  task automatic wait_done(input int k);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((k == 0 && done_a) || (k == 1 && done_b)) return;
    end
    timeout("wait_done");
  endtask

  int sk[6] = '{0, 1, 5, 2, 3, 4};

  // ---------------- directed sequence ----------------
  initial begin
    int acc;
    bit r;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_in_ready", 64'(rdy_a), 0);
    chk("rst_we", 64'(we_a), 0);
    chk("rst_addr", 64'(addr_a), 0);
    chk("rst_wdata", 64'(wd_a), 0);
    chk("rst_busy_done", 64'({busy_a, done_a}), 0);
    chk("rst_count_err", 64'({cnt_a, err_a}), 0);
    tick();
    rst = 1'b0;

    // R-type encoding
    log_a.delete();
    pulse_start(1, 0);
    send(0, 1, 2, 3, 0, 0, 0);
    send(1, 1, 2, 3, 0, 0, 0);
    send(3, 1, 2, 3, 0, 0, 0);
    do_seal();
    wait_done(0);
    chk("r_nwrites", 64'(log_a.size()), 3);
    chk_log("r_w0", 0, 0, {8'd0, 32'h00221800});
    chk_log("r_w1", 0, 1, {8'd1, 32'h00221801});
    chk_log("r_w2", 0, 2, {8'd2, 32'h00221803});
    chk("r_count", 64'(cnt_a), 3);
    chk("r_done", 64'(done_a), 1);

    // I-type encoding
    log_a.delete();
    pulse_start(1, 0);
    send(4, 4, 5, 0, 'h0010, 0, 0);
    send(6, 1, 2, 0, 'hFFFF, 0, 0);
    do_seal();
    wait_done(0);
    chk("i_nwrites", 64'(log_a.size()), 2);
    chk_log("i_lw", 0, 0, {8'd0, 32'h04850010});
    chk_log("i_beq", 0, 1, {8'd1, 32'h0C22FFFF});

    // Memory stall: 10 cycles with imem_ready low, then release
    log_a.delete();
    pulse_start(1, 0);
    imem_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      drive(sk[acc], acc + 1, acc + 2, acc + 3, 'h100 + acc);
      @(negedge clk); r = rdy_a;
      tick();
      if (r) acc++;
    end
    chk("stall_held", 64'(acc), 5);
    @(negedge clk);
    chk("stall_in_ready", 64'(rdy_a), 0);
    chk("stall_we", 64'(we_a), 1);
    imem_ready = 1'b1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      drive(sk[acc], acc + 1, acc + 2, acc + 3, 'h100 + acc);
      @(negedge clk); r = rdy_a;
      tick();
      if (r) acc++;
    end
    in_valid = 1'b0;
    do_seal();
    wait_done(0);
    chk("stall_nwrites", 64'(log_a.size()), 6);
    for (int i = 0; i < 6; i++)
      chk_log($sformatf("stall_w%0d", i), 0, i, {8'(i), ref_word(sk[i], i + 1, i + 2, i + 3, 'h100 + i)});

    // Address limit on the ADDR_W=2 instance
    log_b.delete();
    pulse_start(0, 1);
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (acc < 6) drive(acc % 4, acc, acc + 1, acc + 2, 0); else in_valid = 1'b0;
      @(negedge clk); r = rdy_b;
      tick();
      if (r && in_valid) acc++;
    end
    in_valid = 1'b0;
    chk("alim_accepted", 64'(acc), 4);
    do_seal();
    wait_done(1);
    chk("alim_count", 64'(cnt_b), 4);
    chk("alim_nwrites", 64'(log_b.size()), 4);
    for (int i = 0; i < 4; i++)
      chk_log($sformatf("alim_w%0d", i), 1, i, {8'(i), ref_word(i, i, i + 1, i + 2, 0)});

    // Reset in DRAIN with one write pending and two words queued
    log_a.delete();
    pulse_start(1, 0);
    imem_ready = 1'b0;
    send(0, 1, 1, 1, 0, 0, 0);
    send(1, 2, 2, 2, 0, 0, 0);
    send(2, 3, 3, 3, 0, 0, 0);
    do_seal();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mrst_we_addr", 64'({we_a, addr_a}), 0);
    chk("mrst_wdata", 64'(wd_a), 0);
    chk("mrst_flags", 64'({rdy_a, busy_a, done_a, err_a}), 0);
    chk("mrst_count", 64'(cnt_a), 0);
    rst = 1'b0;
    imem_ready = 1'b1;
    repeat (5) tick();
    chk("mrst_no_writes", 64'(log_a.size()), 0);

    // Seal coincident with an accepted beat
    log_a.delete();
    pulse_start(1, 0);
    send(2, 7, 8, 9, 0, 1, 0);
    wait_done(0);
    chk("seal_nwrites", 64'(log_a.size()), 1);
    chk_log("seal_w0", 0, 0, {8'd0, 32'h00E84802});
    chk("seal_count", 64'(cnt_a), 1);

    // Illegal kind
    log_a.delete();
    pulse_start(1, 0);
    send(7, 3, 4, 5, 'h55, 0, 0);
    send(0, 1, 2, 3, 0, 0, 0);
    do_seal();
    wait_done(0);
`ifdef ENC_ILLEGAL_CHECK_EN
    chk("ill_nwrites", 64'(log_a.size()), 1);
    chk_log("ill_w0", 0, 0, {8'd0, 32'h00221800});
    chk("ill_err", 64'(err_a), 1);
    pulse_start(1, 0);
    @(negedge clk);
    chk("ill_err_cleared", 64'(err_a), 0);
    do_seal();
    wait_done(0);
`else
    chk("ill_nwrites", 64'(log_a.size()), 2);
    chk_log("ill_w0", 0, 0, {8'd0, 32'h00000000});
    chk_log("ill_w1", 0, 1, {8'd1, 32'h00221800});
    chk("ill_err", 64'(err_a), 0);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_stream_encoder.md
# instr_stream_encoder

Instruction-stream encoder and loader. It accepts symbolic instruction requests (ADD/SUB/AND/OR, LW, SW, BEQ) over a valid/ready handshake and packs each one into a 32-bit instruction word using the same opcode/func map the single-cycle controller decodes. Words are buffered in a small FIFO and written to consecutive instruction-memory addresses. It sits between the test/boot sequencer and the instruction memory write port.

## Interface
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- ADDR_W, 8: instruction-memory word-address width.
- BASE_ADDR, 0: first write address after each `start`.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  pulse; begins a load session. Honoured only in IDLE or DONE.
- seal  in  1  pulse; ends request acceptance. Honoured only in RUN.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when `in_valid & in_ready` at the edge.
- in_kind  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 LW, 5 SW, 6 BEQ, 7 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate for LW/SW/BEQ; ignored for R-type.
- imem_we  out  1  write strobe.
- imem_ready  in  1  memory accepts the write when `imem_we & imem_ready`.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  instruction word.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- count  out  ADDR_W+1  completed writes this session.
- err  out  1  sticky illegal-request flag (macro-dependent; see Configuration).

## Operation
- **Encoding:**
  - R-type: {6'd0, rs, rt, rd, 5'd0, func}, with func = in_kind (ADD 0, SUB 1, AND 2, OR 3).
  - LW: {6'd1, rs, rt, imm}.
  - SW: {6'd2, rs, rt, imm}.
  - BEQ: {6'd3, rs, rt, imm}.
- **States:**
  - IDLE: the reset state.
  - IDLE or DONE to RUN on `start`. This clears `count` and `err` and loads the address counter with BASE_ADDR.
  - RUN to DRAIN on `seal`. A beat accepted in the same cycle as `seal` is kept.
  - DRAIN to DONE when the FIFO is empty and no write is pending.
  - `start` in RUN or DRAIN is ignored.
- **Request acceptance:** `in_ready` = RUN & FIFO not full & (count + FIFO occupancy + pending write) < 2^ADDR_W. Address space is never overrun; the address does not wrap.
- **Accepted beats:** encoded combinationally and pushed into the FIFO at the accepting edge.
- **Write port:**
  - When no write is pending and the FIFO is non-empty, pop one word into the `imem_*` output registers, set `imem_we`, and use the current address.
  - While `imem_we & !imem_ready`, hold addr, wdata and we stable.
  - On `imem_we & imem_ready`: increment the address and `count`; pop the next word in the same edge if one is available, otherwise drop `imem_we`.
- **Simultaneous push and pop:** both happen on the same edge; FIFO occupancy is unchanged.
- **Reset (any time, including mid-session):**
  - Empty the FIFO and abort any pending write with no partial write.
  - State returns to IDLE.
  - Output reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `busy` 0, `done` 0, `count` 0, `err` 0.

## Timing
- A beat accepted at edge N, with the FIFO empty and no write pending, pops at edge N+1. `imem_we` is visible after edge N+1.
- Sustained throughput is one write per cycle when `imem_ready` = 1.
- `in_ready` rises in the cycle after the edge that enters RUN.
- `done` rises in the cycle after the last write completes.
- `count` updates on the completing edge.

## Configuration
- **`ENC_ILLEGAL_CHECK_EN` defined:**
  - A kind-7 beat completes its handshake but is not pushed.
  - `err` is set at that edge and stays high until `start` or `rst`.
- **`ENC_ILLEGAL_CHECK_EN` undefined:**
  - A kind-7 beat is encoded as 32'h00000000 (ADD r0,r0,r0) and written normally.
  - `err` is tied 0.

## Structure
- Shared package `instr_pkg` holds:
  - opcode constants OP_RTYPE=0, OP_LW=1, OP_SW=2, OP_BEQ=3;
  - func constants FUNC_ADD..FUNC_OR = 0..3;
  - the in_kind enum;
  - a pure encode function.
- The controller imports the same constants.
- One sub-module, `instr_fifo`: a synchronous FIFO (DEPTH, width 32) with push, pop, full, empty and occupancy outputs.

## Test plan
- **R-type encoding:** start, then ADD rs=1 rt=2 rd=3, SUB same fields, OR same fields, then seal. Expect writes 32'h00221800 @0, 32'h00221801 @1, 32'h00221803 @2; `count`=3; `done`=1.
- **I-type encoding:** LW rs=4 rt=5 imm=0x0010, then BEQ rs=1 rt=2 imm=0xFFFF. Expect 32'h04850010, then 32'h0C22FFFF.
- **Memory stall:** hold `imem_ready`=0 for 10 cycles while pushing 6 beats. Expect `in_ready` low after DEPTH+1 beats are held, outputs stable throughout, and no word lost or duplicated after release.
- **Address limit:** ADDR_W=2 and 6 requests. Expect `in_ready` low after the 4th beat, writes @0..3 only, and `count`=4 after seal.
- **Reset and seal edge cases:** assert `rst` mid-DRAIN with 2 words queued. Expect all outputs at reset values next cycle and no further writes. Separately, `seal` with a coincident valid beat: that beat is written.
- **Illegal kind:** send kind 7. With the macro defined, expect no write and `err`=1 until the next `start`. With it undefined, expect a 32'h00000000 write.
